// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit in front of the unified memory data port.
//   Decodes funct3 into byte enables. Drives a strobe/busy handshake with the memory.
//   Sign- or zero-extends load data for writeback. Flags misaligned requests and busy timeouts.
// Latency: a store completes after 1 ACCESS cycle. A load takes ACCESS + RESP, so wb_valid
//   rises 2 cycles after acceptance. Each cycle with mem_busy high adds one cycle.
// Backpressure: req_ready is high only in IDLE. stall_req freezes the pipeline from the
//   acceptance cycle until the access finishes. The request is accepted on req_valid & req_ready.
// Ports:
//   clk, rst                           clock; synchronous active-high reset
//   req_valid/write/funct3/addr/wdata/rd, req_ready   request from the EX/MEM latch
//   stall_req                          pipeline stall request
//   mem_valid/write/byte/addr/wdata    memory data-port drive
//   mem_rdata, mem_busy                memory data-port response
//   wb_valid/wb_rd/wb_data             load writeback
//   misalign, bus_err                  one-cycle error pulses
module mem_access_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        req_ready,
   output logic        stall_req,
   output logic        mem_valid,
   output logic        mem_write,
   output logic [3:0]  mem_byte,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_busy,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        misalign,
   output logic        bus_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [2:0]       f3_q, f3_d;
   logic             write_q, write_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [4:0]       rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic             misalign_q, misalign_d;
   logic             bus_err_q, bus_err_d;

   logic             req_aligned;
   logic [3:0]       byte_en;
   logic [31:0]      ext_data;

   // Alignment check on the incoming request.
   // Undefined funct3 encodings fall through to "not aligned".
   always_comb begin
      req_aligned = 1'b0;
      case (req_funct3)
         3'b000, 3'b100: req_aligned = 1'b1;
         3'b001, 3'b101: req_aligned = ~req_addr[0];
         3'b010:         req_aligned = (req_addr[1:0] == 2'b00);
         default:        req_aligned = 1'b0;
      endcase
   end

   // Byte enables depend only on the access size, which is held in funct3[1:0].
   always_comb begin
      byte_en = 4'b0000;
      case (f3_q[1:0])
         2'b00:   byte_en = 4'b0001;
         2'b01:   byte_en = 4'b0011;
         2'b10:   byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   end

   always_comb begin
      ext_data = mem_rdata;
      case (f3_q)
         3'b000:  ext_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
         3'b100:  ext_data = {24'h0, mem_rdata[7:0]};
         3'b001:  ext_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
         3'b101:  ext_data = {16'h0, mem_rdata[15:0]};
         default: ext_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      f3_d       = f3_q;
      write_d    = write_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      wb_data_d  = wb_data_q;
      wb_rd_d    = wb_rd_q;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;
      req_ready  = 1'b0;
      stall_req  = 1'b0;
      mem_valid  = 1'b0;
      mem_write  = 1'b0;
      mem_byte   = 4'b0000;
      mem_addr   = 32'h0;
      mem_wdata  = 32'h0;
      wb_valid   = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_aligned) begin
                  // Stall already in the acceptance cycle so the pipeline has no gap.
                  stall_req = 1'b1;
                  addr_d    = req_addr;
                  f3_d      = req_funct3;
                  write_d   = req_write;
                  wdata_d   = req_wdata;
                  rd_d      = req_rd;
                  cnt_d     = '0;
                  state_d   = ACCESS;
               end else begin
                  misalign_d = 1'b1;
               end
            end
         end

         ACCESS: begin
            mem_valid = 1'b1;
            mem_write = write_q;
            mem_byte  = byte_en;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            stall_req = 1'b1;
            if (!mem_busy) begin
               if (write_q) begin
                  state_d = IDLE;
               end else begin
                  wb_data_d = ext_data;
                  wb_rd_d   = rd_q;
                  state_d   = RESP;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_d == TIMEOUT_C) begin
                  bus_err_d = 1'b1;
                  state_d   = IDLE;
               end
            end
         end

         RESP: begin
            wb_valid = 1'b1;
            state_d  = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= 32'h0;
         f3_q       <= 3'b000;
         write_q    <= 1'b0;
         wdata_q    <= 32'h0;
         rd_q       <= 5'd0;
         cnt_q      <= '0;
         wb_data_q  <= 32'h0;
         wb_rd_q    <= 5'd0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         f3_q       <= f3_d;
         write_q    <= write_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign wb_data  = wb_data_q;
   assign wb_rd    = wb_rd_q;
   assign misalign = misalign_q;
   assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit.
// Reference model: expected events, memory accesses and extension results per request.
// The scoreboard is checked by a negedge monitor.
module tb_mem_access_unit;

   localparam int TMO = 4;
   localparam int EV_WB = 0, EV_MIS = 1, EV_BERR = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic [4:0]  req_rd = 5'd0;
   logic        req_ready, stall_req, mem_valid, mem_write;
   logic [3:0]  mem_byte;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_busy = 1'b0;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        misalign, bus_err;

   typedef struct {
      int          kind;
      logic [4:0]  rd;
      logic [31:0] data;
   } ev_t;

   typedef struct {
      logic        write;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } acc_t;

   ev_t  ev_q[$];
   acc_t acc_q[$];
   int   nvec = 0;
   int   nerr = 0;

   mem_access_unit #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .req_ready(req_ready), .stall_req(stall_req),
      .mem_valid(mem_valid), .mem_write(mem_write), .mem_byte(mem_byte),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_busy(mem_busy),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .misalign(misalign), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // Access size in bytes; 0 marks an undefined funct3.
   function automatic int size_of(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] r);
      longint v;
      case (f3)
         3'd0: begin v = r % 256;   if (v >= 128)   v = v - 256;   end
         3'd4: v = r % 256;
         3'd1: begin v = r % 65536; if (v >= 32768) v = v - 65536; end
         3'd5: v = r % 65536;
         default: v = r;
      endcase
      return v[31:0];
   endfunction

   task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rdata, input int nbusy);
      int   sz;
      bit   ok;
      bit   done;
      acc_t ac;
      ev_t  ev;
      sz = size_of(f3);
      ok = (sz != 0) && ((a % sz) == 0);
      if (!ok) begin
         ev.kind = EV_MIS; ev.rd = 5'd0; ev.data = 32'h0;
         ev_q.push_back(ev);
      end else begin
         ac.write = w; ac.be = 4'((1 << sz) - 1); ac.addr = a; ac.wdata = wd;
         acc_q.push_back(ac);
         if (nbusy >= TMO) begin
            ev.kind = EV_BERR; ev.rd = 5'd0; ev.data = 32'h0;
            ev_q.push_back(ev);
         end else if (!w) begin
            ev.kind = EV_WB; ev.rd = rd; ev.data = extend(f3, rdata);
            ev_q.push_back(ev);
         end
      end
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a;
      req_wdata = wd; req_rd = rd; mem_rdata = rdata; mem_busy = 1'b0;
      #1;
      nvec++;
      if (stall_req !== ok || req_ready !== 1'b1) begin
         nerr++;
         $display("FAIL accept_cycle stall=%b ready=%b expected stall=%b ready=1",
                  stall_req, req_ready, ok);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (ok) begin
         done = 1'b0;
         for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (!mem_valid) begin
               done = 1'b1;
               break;
            end
            mem_busy = (c < nbusy);
         end
         mem_busy = 1'b0;
         if (!done) begin
            nerr++;
            $display("FAIL access_end_timeout mem_valid=%b expected 0 within 64 cycles", mem_valid);
         end
         if (!req_ready) @(negedge clk);
      end
   endtask

   task automatic chk_ev(input int kind);
      ev_t e;
      nvec++;
      if (ev_q.size() == 0) begin
         nerr++;
         $display("FAIL unexpected_event kind=%0d rd=%0d data=%h expected none", kind, wb_rd, wb_data);
      end else begin
         e = ev_q.pop_front();
         if (e.kind != kind || (kind == EV_WB && (wb_rd !== e.rd || wb_data !== e.data))) begin
            nerr++;
            $display("FAIL event kind=%0d rd=%0d data=%h expected kind=%0d rd=%0d data=%h",
                     kind, wb_rd, wb_data, e.kind, e.rd, e.data);
         end
      end
   endtask

   // Monitor: compares each memory strobe cycle and each event pulse against the scoreboard.
   logic prev_mv = 1'b0;
   bit   cur_ok = 1'b0;
   acc_t cur;
   always @(negedge clk) begin
      if (mem_valid) begin
         if (!prev_mv) begin
            if (acc_q.size() == 0) begin
               nvec++; nerr++; cur_ok = 1'b0;
               $display("FAIL unexpected_access addr=%h expected no access", mem_addr);
            end else begin
               cur = acc_q.pop_front();
               cur_ok = 1'b1;
            end
         end
         if (cur_ok) begin
            nvec++;
            if (mem_addr !== cur.addr || mem_byte !== cur.be || mem_write !== cur.write ||
                (cur.write && mem_wdata !== cur.wdata) || stall_req !== 1'b1 || req_ready !== 1'b0) begin
               nerr++;
               $display("FAIL access addr=%h be=%b we=%b wd=%h stall=%b rdy=%b expected addr=%h be=%b we=%b wd=%h stall=1 rdy=0",
                        mem_addr, mem_byte, mem_write, mem_wdata, stall_req, req_ready,
                        cur.addr, cur.be, cur.write, cur.wdata);
            end
         end
      end
      prev_mv = mem_valid;
      if (wb_valid) chk_ev(EV_WB);
      if (misalign) chk_ev(EV_MIS);
      if (bus_err)  chk_ev(EV_BERR);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      acc_t ac;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      nvec++;
      if (req_ready !== 1'b1 || stall_req !== 1'b0 || mem_valid !== 1'b0 || mem_write !== 1'b0 ||
          mem_byte !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || wb_valid !== 1'b0 ||
          wb_rd !== 5'd0 || wb_data !== 32'h0 || misalign !== 1'b0 || bus_err !== 1'b0) begin
         nerr++;
         $display("FAIL reset_state ready=%b stall=%b mv=%b wb=%b data=%h expected ready=1, all else 0",
                  req_ready, stall_req, mem_valid, wb_valid, wb_data);
      end

      // Directed cases.
      issue(1'b0, 3'd0, 32'h103, 32'h0, 5'd3, 32'h000000F0, 0);
      issue(1'b0, 3'd5, 32'h102, 32'h0, 5'd4, 32'h00008001, 0);
      issue(1'b0, 3'd1, 32'h102, 32'h0, 5'd5, 32'h00008001, 0);
      issue(1'b1, 3'd2, 32'h200, 32'hDEADBEEF, 5'd0, 32'h0, 3);
      issue(1'b0, 3'd2, 32'h201, 32'h0, 5'd6, 32'h12345678, 0);
      issue(1'b0, 3'd2, 32'h204, 32'h0, 5'd7, 32'h12345678, 0);
      issue(1'b0, 3'd2, 32'h208, 32'h0, 5'd8, 32'hCAFEF00D, 9);
      issue(1'b1, 3'd1, 32'h20A, 32'h0000BEEF, 5'd0, 32'h0, 4);
      issue(1'b0, 3'd3, 32'h210, 32'h0, 5'd9, 32'h0, 0);
      issue(1'b0, 3'd4, 32'h211, 32'h0, 5'd10, 32'hFFFFFF80, 3);

      // Reset in the middle of an access: the access is abandoned without any event.
      ac.write = 1'b0; ac.be = 4'b1111; ac.addr = 32'h300; ac.wdata = 32'h0;
      acc_q.push_back(ac);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300; req_rd = 5'd11;
      mem_rdata = 32'h55AA55AA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk) mem_busy = 1'b1;
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_busy = 1'b0;
      nvec++;
      if (mem_valid !== 1'b0 || stall_req !== 1'b0 || req_ready !== 1'b1 || wb_valid !== 1'b0 || bus_err !== 1'b0) begin
         nerr++;
         $display("FAIL reset_mid_access mv=%b stall=%b ready=%b wb=%b berr=%b expected 0 0 1 0 0",
                  mem_valid, stall_req, req_ready, wb_valid, bus_err);
      end
      repeat (6) @(negedge clk);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         logic        w;
         logic [2:0]  f3;
         logic [31:0] a;
         int          nb;
         w  = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom & 32'h0000FFFF;
         nb = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 3) : $urandom_range(0, 3);
         issue(w, f3, a, $urandom, 5'($urandom_range(0, 31)), $urandom, nb);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      nvec++;
      if (ev_q.size() != 0 || acc_q.size() != 0) begin
         nerr++;
         $display("FAIL leftover_expectations events=%0d accesses=%0d expected 0 0", ev_q.size(), acc_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
